// File: rtl/rs232_tx_if.sv
// Transmit-side bundle: FIFO pop handshake plus serial line and status outputs.
// The master modport is the transmitter; the slave modport is its environment.
interface rs232_tx_if;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_pop, tx, busy, tx_done
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_pop, tx, busy, tx_done
  );
endinterface

// File: rtl/rs232_tx.sv
// RS232 transmitter draining the transmit FIFO as 8N1/8N2 frames, LSB first.
// Define RS232_TX_PARITY_EN to insert one even-parity bit before stop (8E1/8E2).
module rs232_tx #(
  parameter int CLK_DIV       = 434,
  parameter int STOP_BITS     = 1,
  parameter int FETCH_LATENCY = 2
) (
  input  logic       clk,
  input  logic       clear,
  rs232_tx_if.master bus
);

`ifdef RS232_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  fetch_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        stop_cnt;
  logic        tx_r;
  logic        busy_r;
  logic        pop_r;
  logic        done_r;
  logic        bit_end;

  assign bit_end = (baud_cnt == 16'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      fetch_cnt <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      stop_cnt  <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      pop_r     <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      pop_r  <= 1'b0;
      done_r <= 1'b0;
      // Bit periods restart from zero at every boundary, so timing never drifts.
      if (state == IDLE || state == FETCH || bit_end)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 16'd1;

      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (bus.enable && !bus.fifo_empty) begin
            pop_r     <= 1'b1;
            busy_r    <= 1'b1;
            fetch_cnt <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          // Latch on the FETCH_LATENCY-th edge, then drop the line one edge later.
          fetch_cnt <= fetch_cnt + 3'd1;
          if (fetch_cnt == 3'(FETCH_LATENCY - 1))
            shreg <= bus.fifo_data;
          if (fetch_cnt == 3'(FETCH_LATENCY)) begin
            tx_r  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_r    <= shreg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef RS232_TX_PARITY_EN
              tx_r    <= even_parity(shreg);
              state   <= PARITY;
`else
              tx_r     <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end else begin
              tx_r    <= shreg[bit_idx + 3'd1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef RS232_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_r     <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              done_r <= 1'b1;
              busy_r <= 1'b0;
              state  <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx       = tx_r;
  assign bus.busy     = busy_r;
  assign bus.fifo_pop = pop_r;
  assign bus.tx_done  = done_r;

endmodule

// File: tb/tb_rs232_tx.sv
// Randomized self-checking bench for rs232_tx with a FIFO latency model and a
// frame-level reference model built from the serial frame format.
module tb_rs232_tx;
  localparam int CD = 4;
  localparam int FL = 2;
`ifdef RS232_TX_PARITY_EN
  localparam int SB  = 2;
  localparam int PAR = 1;
`else
  localparam int SB  = 1;
  localparam int PAR = 0;
`endif

  logic clk   = 1'b0;
  logic clear = 1'b1;

  rs232_tx_if bus ();

  rs232_tx #(.CLK_DIV(CD), .STOP_BITS(SB), .FETCH_LATENCY(FL)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO model: tasks own wr_ptr, the model process owns rd_ptr and fifo_data.
  logic [7:0] fifo_mem [64];
  int         wr_ptr    = 0;
  int         rd_ptr    = 0;
  int         pop_count = 0;
  int         wait_n    = -1;
  bit         hold      = 1'b0;
  logic [7:0] pend      = 8'h00;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  // Data is valid only around the FETCH_LATENCY-th edge after a pop; garbage otherwise.
  always @(negedge clk) begin
    if (hold) begin
      bus.fifo_data = 8'($urandom);
      hold = 1'b0;
    end
    if (bus.fifo_pop === 1'b1) begin
      if (wr_ptr == rd_ptr) begin
        errors++;
        $display("FAIL pop_when_empty: fifo_pop=1 with fifo_empty=1, required no pop");
      end else begin
        pend = fifo_mem[rd_ptr % 64];
        rd_ptr++;
      end
      pop_count++;
      wait_n = FL - 1;
    end
    if (wait_n == 0) begin
      bus.fifo_data = pend;
      hold = 1'b1;
    end
    if (wait_n >= 0) wait_n--;
  end

  // Expected {tx,busy,tx_done,fifo_pop} per cycle, from the pop sample to the done sample.
  logic [3:0] exp_v [$];

  function automatic void model_frame(input logic [7:0] d);
    logic bits [$];
    exp_v.delete();
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(d[k]);
    if (PAR == 1) bits.push_back(^d);
    for (int k = 0; k < SB; k++) bits.push_back(1'b1);
    exp_v.push_back(4'b1101);
    for (int k = 0; k < FL; k++) exp_v.push_back(4'b1100);
    foreach (bits[j])
      for (int c = 0; c < CD; c++) exp_v.push_back({bits[j], 3'b100});
    exp_v.push_back(4'b1010);
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  task automatic wait_pop(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = (bus.fifo_pop === 1'b1);
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = (bus.tx_done === 1'b1);
    end
  endtask

  task automatic test_reset();
    bit ok;
    clear = 1'b1;
    bus.enable = 1'b1;
    push_byte(8'h96);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.tx, bus.busy, bus.fifo_pop} !== 3'b100) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: tx/busy/pop=%b required 100", i, {bus.tx, bus.busy, bus.fifo_pop});
      end
    end
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fifo_pop !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_pop: fifo_pop=%b required 1", bus.fifo_pop);
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_frame_done: tx_done=0 after bound, required 1");
    end
  endtask

  task automatic test_single(input logic [7:0] d, input string name);
    bit ok;
    push_byte(d);
    wait_pop(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_pop byte %h: fifo_pop=0 after bound, required 1", name, d);
      return;
    end
    model_frame(d);
    foreach (exp_v[i]) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({bus.tx, bus.busy, bus.tx_done, bus.fifo_pop} !== exp_v[i]) begin
        errors++;
        $display("FAIL %s byte %h cycle %0d: tx/busy/done/pop=%b required %b",
                 name, d, i, {bus.tx, bus.busy, bus.tx_done, bus.fifo_pop}, exp_v[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      test_single(b, "random");
    end
  endtask

  task automatic test_back_to_back();
    bit         ok;
    int         pc0;
    logic [7:0] bytes [2];
    bytes[0] = 8'hA5;
    bytes[1] = 8'h3C;
    pc0 = pop_count;
    push_byte(bytes[0]);
    push_byte(bytes[1]);
    for (int f = 0; f < 2; f++) begin
      wait_pop((f == 0) ? 20 : 1, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_pop%0d: fifo_pop=0 at required cycle, required 1", f);
        continue;
      end
      model_frame(bytes[f]);
      foreach (exp_v[i]) begin
        if (i > 0) @(negedge clk);
        checks++;
        if ({bus.tx, bus.busy, bus.tx_done, bus.fifo_pop} !== exp_v[i]) begin
          errors++;
          $display("FAIL b2b byte %h cycle %0d: tx/busy/done/pop=%b required %b",
                   bytes[f], i, {bus.tx, bus.busy, bus.tx_done, bus.fifo_pop}, exp_v[i]);
        end
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (pop_count - pc0 != 2) begin
      errors++;
      $display("FAIL b2b_pop_count: pops=%0d required 2", pop_count - pc0);
    end
  endtask

  task automatic test_enable_drop();
    bit         ok;
    int         pc0;
    int         drop_idx;
    logic [7:0] b;
    b = 8'($urandom);
    drop_idx = FL + 1 + CD * 3 + 1;
    pc0 = pop_count;
    push_byte(b);
    push_byte(8'($urandom));
    wait_pop(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL endrop_pop: fifo_pop=0 after bound, required 1");
    end else begin
      model_frame(b);
      foreach (exp_v[i]) begin
        if (i > 0) @(negedge clk);
        checks++;
        if ({bus.tx, bus.busy, bus.tx_done, bus.fifo_pop} !== exp_v[i]) begin
          errors++;
          $display("FAIL endrop byte %h cycle %0d: tx/busy/done/pop=%b required %b",
                   b, i, {bus.tx, bus.busy, bus.tx_done, bus.fifo_pop}, exp_v[i]);
        end
        if (i == drop_idx) bus.enable = 1'b0;
      end
    end
    repeat (30) @(negedge clk);
    checks++;
    if (pop_count - pc0 != 1 || bus.fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL endrop_no_pop: pops=%0d empty=%b required pops=1 empty=0", pop_count - pc0, bus.fifo_empty);
    end
    wr_ptr = rd_ptr;
    bus.enable = 1'b1;
  endtask

  task automatic test_clear_mid();
    bit         ok;
    int         clr_idx;
    int         bad;
    logic [7:0] b;
    b = 8'($urandom);
    clr_idx = FL + 1 + CD * 4 + 1;
    push_byte(b);
    wait_pop(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clear_pop: fifo_pop=0 after bound, required 1");
      return;
    end
    model_frame(b);
    for (int i = 0; i <= clr_idx; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({bus.tx, bus.busy, bus.tx_done, bus.fifo_pop} !== exp_v[i]) begin
        errors++;
        $display("FAIL clear_pre byte %h cycle %0d: tx/busy/done/pop=%b required %b",
                 b, i, {bus.tx, bus.busy, bus.tx_done, bus.fifo_pop}, exp_v[i]);
      end
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if ({bus.tx, bus.busy, bus.tx_done, bus.fifo_pop} !== 4'b1000) begin
      errors++;
      $display("FAIL clear_next_edge: tx/busy/done/pop=%b required 1000", {bus.tx, bus.busy, bus.tx_done, bus.fifo_pop});
    end
    bad = 0;
    for (int i = 0; i < 12 * CD; i++) begin
      @(negedge clk);
      if ({bus.tx, bus.busy, bus.tx_done, bus.fifo_pop} !== 4'b1000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_quiet: %0d cycles off idle, required 0", bad);
    end
    push_byte(8'($urandom));
    wait_pop(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clear_fresh_pop: fifo_pop=0 on first edge, required 1");
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clear_fresh_done: tx_done=0 after bound, required 1");
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    test_reset();
    test_single(8'h55, "single55");
    test_single(8'h07, "single07");
    test_random();
    test_back_to_back();
    test_enable_drop();
    test_clear_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
